// File: rtl/video_mode_sequencer_pkg.sv
// Shared types and cfg field positions for the video mode sequencer.
// Holds the state encoding and the keyboard VGA/RGB toggle rule.
package video_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VS  = 2'd1,
    BLANKING = 2'd2
  } state_t;

  localparam int VGA       = 0;
  localparam int SCANL     = 1;
  localparam int FREQ_LSB  = 2;
  localparam int FREQ_MSB  = 4;
  localparam int CSYNC     = 5;
  localparam int SPEED_LSB = 6;
  localparam int SPEED_MSB = 7;

  // Switching to VGA forces the fastest refresh; going back to RGB restores 50 Hz.
  function automatic logic [7:0] kbd_toggle_cfg(input logic [7:0] t);
    logic [7:0] r;
    r[SPEED_MSB:CSYNC]  = t[SPEED_MSB:CSYNC];
    r[FREQ_MSB:FREQ_LSB] = t[VGA] ? 3'b000 : 3'b111;
    r[SCANL]            = t[SCANL];
    r[VGA]              = ~t[VGA];
    return r;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_if.sv
// Request/config bundle between I/O decode (master) and the sequencer (slave).
interface video_mode_sequencer_if;
  logic       zxuno_req;
  logic [7:0] zxuno_cfg;
  logic       prism_req;
  logic [1:0] prism_cfg;
  logic       kbd_toggle;
  logic       vsync_n;
  logic [7:0] cfg;
  logic [7:0] target;
  logic       blank;
  logic       busy;
  logic       done;

  modport master (
    output zxuno_req, zxuno_cfg, prism_req, prism_cfg, kbd_toggle, vsync_n,
    input  cfg, target, blank, busy, done
  );

  modport slave (
    input  zxuno_req, zxuno_cfg, prism_req, prism_cfg, kbd_toggle, vsync_n,
    output cfg, target, blank, busy, done
  );
endinterface

// File: rtl/video_mode_sequencer_edge_det.sv
// Registered-history edge detector; rise/fall are combinational from the current input.
// Reset value of the history register is chosen so a level held at reset release is not an edge.
module edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise,
  output logic fall
);
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= RST_VAL;
    else     r_prev <= in;
  end

  assign rise = in & ~r_prev;
  assign fall = ~in & r_prev;
endmodule

// File: rtl/video_mode_sequencer.sv
// Arbitrates cfg change requests, applies them on a vsync fall (or timeout) and blanks for a few frames.
// Outputs are registered: request at edge N shows at N+1; one-deep pending slot, last request wins.
module video_mode_sequencer
  import video_seq_pkg::*;
#(
  parameter logic [7:0] INITIAL_CFG  = 8'h00,
  parameter int         BLANK_FRAMES = 2,
  parameter int         VS_TIMEOUT   = 1_400_000
) (
  input logic                   clk,
  input logic                   rst,
  video_mode_sequencer_if.slave bus
);
  localparam int            TW   = $clog2(VS_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(VS_TIMEOUT);
  localparam logic [3:0]    BF   = 4'(BLANK_FRAMES);

  state_t        r_state;
  logic [7:0]    r_cfg, r_target, r_pend;
  logic          r_pend_vld, r_blank, r_busy, r_done;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_fcnt;

  logic       w_kbd_rise, w_unused_kbd_fall, w_vs_fall, w_unused_vs_rise;
  logic       w_req_vld, w_apply;
  logic [7:0] w_base, w_req_cfg;

  edge_det #(.RST_VAL(1'b1)) u_kbd_edge (
    .clk(clk), .rst(rst), .in(bus.kbd_toggle), .rise(w_kbd_rise), .fall(w_unused_kbd_fall)
  );
  edge_det #(.RST_VAL(1'b1)) u_vs_edge (
    .clk(clk), .rst(rst), .in(bus.vsync_n), .rise(w_unused_vs_rise), .fall(w_vs_fall)
  );

  // Partial (prism) and toggle (kbd) requests build on the newest queued value.
  always_comb begin
    w_base    = r_pend_vld ? r_pend : r_target;
    w_req_vld = 1'b0;
    w_req_cfg = w_base;
    if (bus.zxuno_req) begin
      w_req_vld = 1'b1;
      w_req_cfg = bus.zxuno_cfg;
    end else if (bus.prism_req) begin
      w_req_vld = 1'b1;
      w_req_cfg[SPEED_MSB:SPEED_LSB] = bus.prism_cfg;
    end else if (w_kbd_rise) begin
      w_req_vld = 1'b1;
      w_req_cfg = kbd_toggle_cfg(w_base);
    end
  end

  assign w_apply = (r_state == WAIT_VS) && (w_vs_fall || (r_tcnt == TMAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cfg      <= INITIAL_CFG;
      r_target   <= INITIAL_CFG;
      r_pend     <= INITIAL_CFG;
      r_pend_vld <= 1'b0;
      r_blank    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tcnt     <= '0;
      r_fcnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_vld && (w_req_cfg != r_cfg)) begin
            r_target <= w_req_cfg;
            r_tcnt   <= '0;
            r_busy   <= 1'b1;
            r_state  <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (w_apply) begin
            r_cfg <= r_target;
            if (BLANK_FRAMES > 0) begin
              r_blank <= 1'b1;
              r_fcnt  <= BF;
              r_state <= BLANKING;
              if (w_req_vld) begin
                r_pend     <= w_req_cfg;
                r_pend_vld <= 1'b1;
              end
            end else begin
              r_done <= 1'b1;
              if (w_req_vld) begin
                r_target <= w_req_cfg;
                r_tcnt   <= '0;
              end else begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
            if (w_req_vld) r_target <= w_req_cfg;
          end
        end
        BLANKING: begin
          if (w_vs_fall && (r_fcnt == 4'd1)) begin
            r_blank    <= 1'b0;
            r_done     <= 1'b1;
            r_fcnt     <= '0;
            r_pend_vld <= 1'b0;
            // A request landing on the completion edge supersedes the slot.
            if (w_req_vld || r_pend_vld) begin
              r_target <= w_req_vld ? w_req_cfg : r_pend;
              r_tcnt   <= '0;
              r_state  <= WAIT_VS;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            if (w_vs_fall) r_fcnt <= r_fcnt - 4'd1;
            if (w_req_vld) begin
              r_pend     <= w_req_cfg;
              r_pend_vld <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg    = r_cfg;
  assign bus.target = r_target;
  assign bus.blank  = r_blank;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
endmodule
